// File: rtl/fec_pkg.sv
// fec_pkg: shared state encoding and frame/lock defaults for the 10G-KR FEC lock controller.
package fec_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_WAIT = 2'd2,
    S_LOCK = 2'd3
  } lock_state_t;
  localparam int FEC_FRAME_BLOCKS = 32;
  localparam int FEC_BLK_W = 65;
  localparam int FEC_FRAME_W = FEC_FRAME_BLOCKS * FEC_BLK_W;
  localparam int GOOD_TO_LOCK_DEF = 4;
  localparam int BAD_TO_UNLOCK_DEF = 8;
  localparam int SLIP_WAIT_DEF = 2;
  localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/fec_sat_cnt.sv
// fec_sat_cnt: saturating up-counter with synchronous clear (clear wins over increment).
module fec_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fec_lock_ctrl.sv
// fec_lock_ctrl: FEC frame-lock hunt/lock FSM driving bit slips from per-frame syndrome results.
// Optional FEC_LOCK_STATS_EN adds saturating slip/unlock statistics counters.
module fec_lock_ctrl
  import fec_pkg::*;
#(
  parameter int GOOD_TO_LOCK     = GOOD_TO_LOCK_DEF,
  parameter int BAD_TO_UNLOCK    = BAD_TO_UNLOCK_DEF,
  parameter int SLIP_WAIT_FRAMES = SLIP_WAIT_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        synd_val_i,
  input  logic        synd_zero_i,
  output logic        fec_lock_o,
  output logic        slip_o,
`ifdef FEC_LOCK_STATS_EN
  input  logic        stats_clr_i,
  output logic [15:0] slip_cnt_o,
  output logic [15:0] unlock_cnt_o,
`endif
  output logic [1:0]  lock_state_o
);
  localparam logic [CNT_W-1:0] GOOD_M1 = CNT_W'(GOOD_TO_LOCK - 1);
  localparam logic [CNT_W-1:0] BAD_M1 = CNT_W'(BAD_TO_UNLOCK - 1);
  localparam logic [CNT_W-1:0] WAIT_M1 = CNT_W'(SLIP_WAIT_FRAMES - 1);
  localparam lock_state_t POST_SLIP = (SLIP_WAIT_FRAMES == 0) ? S_TEST : S_WAIT;
  lock_state_t state_q, state_d;
  logic lock_q, lock_d, slip_q, slip_d;
  logic [CNT_W-1:0] good_q, bad_q, wait_q;
  logic good_strb, bad_strb, tst_bad;
  assign good_strb = synd_val_i && synd_zero_i;
  assign bad_strb = synd_val_i && !synd_zero_i;
  // A bad result right after a slip predates the new alignment; never slip twice in a row.
  assign tst_bad = state_q == S_TEST && bad_strb && !slip_q;
  fec_sat_cnt #(.W(CNT_W)) u_good (
    .clk(clk), .rst_n(rst_n),
    .clr_i(!enable_i || state_q != S_TEST || bad_strb),
    .inc_i(state_q == S_TEST && good_strb),
    .cnt_o(good_q)
  );
  fec_sat_cnt #(.W(CNT_W)) u_bad (
    .clk(clk), .rst_n(rst_n),
    .clr_i(!enable_i || state_q != S_LOCK || good_strb),
    .inc_i(state_q == S_LOCK && bad_strb),
    .cnt_o(bad_q)
  );
  fec_sat_cnt #(.W(CNT_W)) u_wait (
    .clk(clk), .rst_n(rst_n),
    .clr_i(!enable_i || state_q != S_WAIT),
    .inc_i(state_q == S_WAIT && synd_val_i),
    .cnt_o(wait_q)
  );
  always_comb begin
    state_d = state_q;
    slip_d = 1'b0;
    if (!enable_i) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: state_d = S_TEST;
      S_TEST: begin
        state_d = (good_strb && good_q == GOOD_M1) ? S_LOCK : tst_bad ? POST_SLIP : S_TEST;
        slip_d = tst_bad;
      end
      S_WAIT: state_d = (synd_val_i && wait_q == WAIT_M1) ? S_TEST : S_WAIT;
      S_LOCK: begin
        slip_d = bad_strb && bad_q == BAD_M1;
        state_d = slip_d ? POST_SLIP : S_LOCK;
      end
    endcase
    lock_d = state_d == S_LOCK;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lock_q <= 1'b0;
      slip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      slip_q <= slip_d;
    end
  end
  assign fec_lock_o = lock_q;
  assign slip_o = slip_q;
  assign lock_state_o = state_q;
`ifdef FEC_LOCK_STATS_EN
  fec_sat_cnt #(.W(16)) u_slip_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(stats_clr_i), .inc_i(slip_q), .cnt_o(slip_cnt_o)
  );
  fec_sat_cnt #(.W(16)) u_unlock_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(stats_clr_i),
    .inc_i(enable_i && state_q == S_LOCK && slip_d), .cnt_o(unlock_cnt_o)
  );
`endif
endmodule

// File: tb/tb_fec_lock_ctrl.sv
// tb_fec_lock_ctrl: table-driven, scoreboarded bench for fec_lock_ctrl (default parameters).
// Define FEC_LOCK_STATS_EN to also exercise the statistics counters.
module tb_fec_lock_ctrl;
  import fec_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, synd_val = 1'b0, synd_zero = 1'b0;
  logic fec_lock, slip;
  logic [1:0] lock_state;
  logic sc_clr = 1'b0, sc_inc = 1'b0;
  logic [2:0] sc_q;
`ifdef FEC_LOCK_STATS_EN
  logic stats_clr = 1'b0;
  logic [15:0] slip_cnt, unlock_cnt;
`endif
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic en, sv, sz;
    logic [3:0] exp;
    string name;
  } vec_t;
  vec_t tv[$];
  logic [3:0] exp_q[$];
  always #5 clk = ~clk;
  fec_lock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .synd_val_i(synd_val), .synd_zero_i(synd_zero),
    .fec_lock_o(fec_lock), .slip_o(slip),
`ifdef FEC_LOCK_STATS_EN
    .stats_clr_i(stats_clr), .slip_cnt_o(slip_cnt), .unlock_cnt_o(unlock_cnt),
`endif
    .lock_state_o(lock_state)
  );
  fec_sat_cnt #(.W(3)) u_sc (.clk(clk), .rst_n(rst_n), .clr_i(sc_clr), .inc_i(sc_inc), .cnt_o(sc_q));
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void add(string nm, logic en, logic sv, logic sz, logic lk, logic sl, logic [1:0] st);
    vec_t v;
    v.en = en; v.sv = sv; v.sz = sz; v.exp = {lk, sl, st}; v.name = nm;
    tv.push_back(v);
  endfunction
  task automatic step(vec_t v);
    enable = v.en; synd_val = v.sv; synd_zero = v.sz;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    chk(v.name, {12'd0, fec_lock, slip, lock_state}, {12'd0, exp_q.pop_front()});
  endtask
  task automatic run_tv();
    foreach (tv[i]) step(tv[i]);
    tv.delete();
  endtask
  task automatic drv(logic en, logic sv, logic sz);
    enable = en; synd_val = sv; synd_zero = sz;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("reset_outputs", {12'd0, fec_lock, slip, lock_state}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // lock acquisition, then unlock hysteresis and re-lock after the slip wait
    add("t1_enable", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("t1_good", 1, 1, 1, 0, 0, 1);
    add("t1_lock", 1, 1, 1, 1, 0, 3);
    add("t1_hold", 1, 0, 0, 1, 0, 3);
    for (int i = 0; i < 7; i++) add("t3_bad_a", 1, 1, 0, 1, 0, 3);
    add("t3_good_clears", 1, 1, 1, 1, 0, 3);
    for (int i = 0; i < 7; i++) add("t3_bad_b", 1, 1, 0, 1, 0, 3);
    add("t3_unlock_slip", 1, 1, 0, 0, 1, 2);
    add("t3_wait1", 1, 1, 1, 0, 0, 2);
    add("t3_wait2", 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("t3_regood", 1, 1, 1, 0, 0, 1);
    add("t3_relock", 1, 1, 1, 1, 0, 3);
    run_tv();
    // disable from lock, fresh hunt with a slip, ignored strobes and unqualified synd_zero
    add("t4_disable", 0, 0, 0, 0, 0, 0);
    add("t4_idle_strobe", 0, 1, 1, 0, 0, 0);
    add("t4_reenable", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("t2_good", 1, 1, 1, 0, 0, 1);
    add("t2_bad_slip", 1, 1, 0, 0, 1, 2);
    add("t2_ignored1", 1, 1, 1, 0, 0, 2);
    add("t2_ignored2", 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) add("t2_good_b", 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("t2_zero_noval", 1, 0, 1, 0, 0, 1);
    add("t2_good_c", 1, 1, 1, 0, 0, 1);
    add("t2_lock", 1, 1, 1, 1, 0, 3);
    for (int i = 0; i < 7; i++) add("t5_bad", 1, 1, 0, 1, 0, 3);
    add("t5_slip", 1, 1, 0, 0, 1, 2);
    run_tv();
    // asynchronous reset mid-wait with slip high
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset", {12'd0, fec_lock, slip, lock_state}, 16'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    add("t5_enable", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("t5_good", 1, 1, 1, 0, 0, 1);
    add("t5_lock", 1, 1, 1, 1, 0, 3);
    run_tv();
    // saturating counter building block
    sc_inc = 1'b1;
    repeat (3) drv(1, 0, 0);
    chk("satcnt_count3", {13'd0, sc_q}, 16'd3);
    repeat (6) drv(1, 0, 0);
    chk("satcnt_saturate", {13'd0, sc_q}, 16'd7);
    sc_clr = 1'b1;
    drv(1, 0, 0);
    chk("satcnt_clr_wins", {13'd0, sc_q}, 16'd0);
    sc_clr = 1'b0;
    drv(1, 0, 0);
    chk("satcnt_after_clr", {13'd0, sc_q}, 16'd1);
    sc_inc = 1'b0;
`ifdef FEC_LOCK_STATS_EN
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drv(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0);
      drv(1, 1, 1);
      drv(1, 1, 1);
    end
    repeat (4) drv(1, 1, 1);
    repeat (8) drv(1, 1, 0);
    drv(1, 0, 0);
    chk("stats_slip_cnt", slip_cnt, 16'd4);
    chk("stats_unlock_cnt", unlock_cnt, 16'd1);
    stats_clr = 1'b1;
    drv(1, 0, 0);
    stats_clr = 1'b0;
    chk("stats_clr_slip", slip_cnt, 16'd0);
    chk("stats_clr_unlock", unlock_cnt, 16'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
